vga_pixel_fetch: RTL and testbench

//  Downstream of the horizontal/vertical sync counters. Turns line/pixel indices into frame-buffer read addresses,

---
 rtl/vga_pixel_fetch_pkg.sv | 21 ++
 rtl/delay_en.sv | 27 ++
 rtl/vga_pixel_fetch.sv | 100 ++++++++++
 tb/tb_vga_pixel_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_fetch_pkg.sv
// Shared VGA 640x480@60 timing constants, RGB332 field positions and the sync/visibility delay word.
// Pure declarations: no latency, no flow control.
package vga_pixel_fetch_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  localparam int R_LSB = 5;
  localparam int G_LSB = 2;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vis;
    logic first;
  } dly_t;

endpackage

// File: rtl/delay_en.sv
// Enable-gated shift register with async active-low clear; DEPTH enabled clocks of latency.
// Holds every stage while en is low.
module delay_en #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Maps visible (hidx, vidx) to upscaled frame-buffer reads and drives RGB332/sync pins 2 pixel ticks later.
// Advances only on i_px_clk; with the tick held low, addresses, pins and syncs hold.
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int ADDR_BITS   = 15,
  parameter int PX_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_px_clk,
  input  logic                 i_hsync_en,
  input  logic                 i_vsync_en,
  input  logic                 i_haddr_en,
  input  logic                 i_vaddr_en,
  input  logic [9:0]           i_hidx,
  input  logic [9:0]           i_vidx,
  output logic                 o_rd_en,
  output logic [ADDR_BITS-1:0] o_rd_addr,
  input  logic [PX_BITS-1:0]   i_rd_data,
  output logic [2:0]           o_red,
  output logic [2:0]           o_green,
  output logic [1:0]           o_blue,
  output logic                 o_hsync_n,
  output logic                 o_vsync_n,
  output logic                 o_frame_start
);

  localparam logic [ADDR_BITS-1:0] LAST_ROW_BASE = ADDR_BITS'(FB_W * (FB_H - 1));

  logic                 vis;
  logic                 row_step;
  logic [ADDR_BITS-1:0] row_base;
  logic                 rd_pend;
  logic [PX_BITS-1:0]   pix_q;
  logic [PX_BITS-1:0]   pix_a;
  dly_t                 dly_d;
  dly_t                 dly_q;

  assign vis = i_haddr_en & i_vaddr_en;

  // Last pixel of the last replicated line of a source row, except the final visible line.
  assign row_step = i_haddr_en && (i_hidx == 10'(H_VISIBLE - 1)) &&
                    (&i_vidx[SCALE_SHIFT-1:0]) && (i_vidx != 10'(V_VISIBLE - 1)) &&
                    (row_base != LAST_ROW_BASE);

  assign dly_d = '{hsync: i_hsync_en,
                   vsync: i_vsync_en,
                   vis:   vis,
                   first: vis && (i_hidx == '0) && (i_vidx == '0)};

  delay_en #(.WIDTH($bits(dly_t)), .DEPTH(2)) u_dly (
    .clk   (clk),
    .rst_n (i_rst_n),
    .en    (i_px_clk),
    .d     (dly_d),
    .q     (dly_q)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_en       <= 1'b0;
      o_rd_addr     <= '0;
      row_base      <= '0;
      rd_pend       <= 1'b0;
      pix_q         <= '0;
      pix_a         <= '0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_hsync_n     <= 1'b1;
      o_vsync_n     <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      rd_pend       <= o_rd_en;
      o_rd_en       <= 1'b0;
      o_frame_start <= 1'b0;
      if (rd_pend) pix_q <= i_rd_data;
      if (i_px_clk) begin
        o_rd_en <= vis;
        if (vis) o_rd_addr <= row_base + ADDR_BITS'(i_hidx >> SCALE_SHIFT);
        if (!i_vaddr_en)   row_base <= '0;
        else if (row_step) row_base <= row_base + ADDR_BITS'(FB_W);
        // Data of the previous tick's read: live if it lands on this edge, else already
        // parked in pix_q because the tick stream stalled after the read.
        pix_a         <= rd_pend ? i_rd_data : pix_q;
        o_red         <= dly_q.vis ? pix_a[R_LSB +: 3] : 3'd0;
        o_green       <= dly_q.vis ? pix_a[G_LSB +: 3] : 3'd0;
        o_blue        <= dly_q.vis ? pix_a[B_LSB +: 2] : 2'd0;
        o_hsync_n     <= ~dly_q.hsync;
        o_vsync_n     <= ~dly_q.vsync;
        o_frame_start <= dly_q.vis & dly_q.first;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: addressing, latency, blanking, sync alignment, stall and reset.
module tb_vga_pixel_fetch;
  import vga_pixel_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        px_clk;
  logic        hsync_en, vsync_en, haddr_en, vaddr_en;
  logic [9:0]  hidx, vidx;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        hsync_n, vsync_n, frame_start;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pixel_fetch dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_px_clk      (px_clk),
    .i_hsync_en    (hsync_en),
    .i_vsync_en    (vsync_en),
    .i_haddr_en    (haddr_en),
    .i_vaddr_en    (vaddr_en),
    .i_hidx        (hidx),
    .i_vidx        (vidx),
    .o_rd_en       (rd_en),
    .o_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .o_red         (red),
    .o_green       (green),
    .o_blue        (blue),
    .o_hsync_n     (hsync_n),
    .o_vsync_n     (vsync_n),
    .o_frame_start (frame_start)
  );

  // Frame-buffer model: one clk read latency, garbage on idle cycles.
  logic ram_ff = 1'b0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_ff ? 8'hFF : (rd_addr == 15'd0 ? 8'hE3 : rd_addr[7:0]);
    else       rd_data <= 8'h5C;
  end

  int rd_cnt = 0;
  int fs_cnt = 0;
  int rd_in_rst = 0;
  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (frame_start) fs_cnt++;
    if (!rst_n && rd_en) rd_in_rst++;
  end

  logic        tk_rd_en, tk_fs;
  logic [14:0] tk_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pins();
    return {red, green, blue};
  endfunction

  // One pixel tick followed by one idle clk; returns just after a negedge.
  task automatic tick(input logic hs, input logic vs, input logic he, input logic ve,
                      input logic [9:0] h, input logic [9:0] v);
    hsync_en = hs; vsync_en = vs; haddr_en = he; vaddr_en = ve;
    hidx = h; vidx = v; px_clk = 1'b1;
    @(posedge clk); @(negedge clk);
    tk_rd_en = rd_en; tk_addr = rd_addr; tk_fs = frame_start;
    px_clk = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic vt(input logic [9:0] h, input logic [9:0] v);
    tick(1'b0, 1'b0, 1'b1, 1'b1, h, v);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
  endtask

  int j, hs_low, vs_low, hs_first, vs_first;

  initial begin
    rst_n = 1'b0; px_clk = 1'b0;
    hsync_en = 1'b0; vsync_en = 1'b0; haddr_en = 1'b0; vaddr_en = 1'b0;
    hidx = '0; vidx = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_rgb", pins(), 0);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency from (0,0) to the pins
    idle(); idle();
    vt(10'd0, 10'd0);
    chk("lat_rd_en", tk_rd_en, 1);
    chk("lat_addr0", tk_addr, 0);
    vt(10'd1, 10'd0);
    chk("lat_rgb_early", pins(), 8'h00);
    vt(10'd2, 10'd0);
    chk("lat_rgb_e3", pins(), 8'hE3);
    chk("lat_fs", tk_fs, 1);
    vt(10'd3, 10'd0);
    chk("lat_rgb_rep", pins(), 8'hE3);
    idle(); idle();
    chk("fs_once", fs_cnt, 1);

    // Addressing and row stepping
    idle();
    vt(10'd5, 10'd0);
    chk("addr_5_0", tk_addr, 1);
    vt(10'd639, 10'd3);
    chk("addr_639_3", tk_addr, 159);
    vt(10'd0, 10'd4);
    chk("addr_0_4", tk_addr, 160);
    idle();
    for (int k = 0; k < 119; k++) vt(10'd639, 10'(4 * k + 3));
    vt(10'd639, 10'd479);
    chk("addr_639_479", tk_addr, 19199);
    vt(10'd0, 10'd479);
    chk("addr_no_step_479", tk_addr, 19040);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 10'd700, 10'd479);
    chk("oow_no_read", tk_rd_en, 0);

    // Blanking with an all-ones frame buffer
    ram_ff = 1'b1;
    idle();
    vt(10'd10, 10'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 10'd650, 10'd0);
    idle();
    chk("blank_vis_ff", pins(), 8'hFF);
    idle();
    chk("blank_hoff", pins(), 8'h00);
    vt(10'd20, 10'd0);
    vt(10'd24, 10'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 10'd28, 10'd0);
    chk("blank_vis_ff2", pins(), 8'hFF);
    idle(); idle();
    chk("blank_voff", pins(), 8'h00);
    ram_ff = 1'b0;

    // Stall mid-line
    idle();
    vt(10'd32, 10'd0); vt(10'd36, 10'd0); vt(10'd40, 10'd0); vt(10'd44, 10'd0);
    chk("stall_pre_rgb", pins(), 8'h09);
    hidx = 10'd300; vidx = 10'd9; hsync_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("stall_addr", rd_addr, 11);
    chk("stall_rgb", pins(), 8'h09);
    chk("stall_hsync", hsync_n, 1);
    vt(10'd48, 10'd0);
    chk("stall_resume_a", pins(), 8'h0A);
    vt(10'd52, 10'd0);
    chk("stall_resume_b", pins(), 8'h0B);

    // Two lines: one visible, one in vertical sync
    idle(); idle();
    rd_cnt = 0; hs_low = 0; vs_low = 0; hs_first = -1; vs_first = -1; j = 0;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < H_TOTAL; i++) begin
        tick(i >= 656 && i < 752, ln == 1, i < H_VISIBLE, ln == 0,
             i < H_VISIBLE ? 10'(i) : 10'd0, 10'd4);
        if (!hsync_n) begin hs_low++; if (hs_first < 0) hs_first = j; end
        if (!vsync_n) begin vs_low++; if (vs_first < 0) vs_first = j; end
        if (j == 700) chk("line_hblank_rgb", pins(), 8'h00);
        j++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      if (!hsync_n) hs_low++;
      if (!vsync_n) vs_low++;
    end
    chk("line_hs_first", hs_first, 658);
    chk("line_hs_low", hs_low, 192);
    chk("line_vs_first", vs_first, 802);
    chk("line_vs_low", vs_low, 800);
    chk("line_rd_cnt", rd_cnt, 640);

    // Asynchronous reset mid-line
    tick(1'b1, 1'b1, 1'b1, 1'b1, 10'd100, 10'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 10'd104, 10'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 10'd108, 10'd0);
    chk("pre_rst_hs", hsync_n, 0);
    chk("pre_rst_rgb", pins(), 8'h19);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rgb", pins(), 8'h00);
    chk("arst_hsync_n", hsync_n, 1);
    chk("arst_vsync_n", vsync_n, 1);
    chk("arst_addr", rd_addr, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 10'(112 + 4 * i), 10'd0);
    rst_n = 1'b1;
    idle();
    chk("post_rst_rgb", pins(), 8'h00);
    idle();
    chk("post_rst_rgb2", pins(), 8'h00);
    chk("rd_in_rst", rd_in_rst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
